// File: rtl/traffic_pkg.sv
// Shared traffic definitions: light encodings used by the controller and the
// vehicle detector, plus the detector state enum.
package traffic_pkg;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SERVE,
      SERVING
   } det_state_t;

   // True only for the exact green encoding; any other pattern is "not green".
   function automatic logic is_green(input logic [2:0] light);
      return light == GREEN;
   endfunction

endpackage

// File: rtl/vehicle_detector_if.sv
// Request/acknowledge link between the vehicle detector and the traffic light
// controller: the detector raises sensor, the controller answers on side_light.
interface vehicle_detector_if;

   logic       sensor;
   logic [2:0] side_light;

   modport master (output sensor, input side_light);
   modport slave  (input sensor, output side_light);

endinterface

// File: rtl/loop_debounce.sv
// Two-flop synchronizer and debounce counter for the inductive loop input.
// Produces the debounced loop level and a one-cycle arrival pulse on its rise.
module loop_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic loop_raw,
   output logic loop_db,
   output logic arrival
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q;
   logic             loop_s;
   logic [CNT_W-1:0] db_cnt;
   logic             settle;

   // The counter never holds DEBOUNCE_CYCLES itself: the edge that would count
   // up to it instead commits the new level and returns the counter to 0.
   assign settle = (loop_s != loop_db) && (db_cnt == CNT_LAST);

   // Bring the asynchronous loop input into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 1'b0;
         loop_s <= 1'b0;
      end else begin
         sync_q <= loop_raw;
         loop_s <= sync_q;
      end
   end

   // Accept a new loop level only after it has differed for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt  <= '0;
         loop_db <= 1'b0;
         arrival <= 1'b0;
      end else begin
         arrival <= settle & loop_s;
         if (loop_s == loop_db) begin
            db_cnt <= '0;
         end else if (settle) begin
            db_cnt  <= '0;
            loop_db <= loop_s;
         end else begin
            db_cnt <= db_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/vehicle_detector.sv
// Side-street vehicle detector: debounced loop, saturating arrival counter and
// a request FSM that holds sensor until the side light turns green.
// Optional stuck-loop detection is built when STUCK_DETECT_EN is defined.
module vehicle_detector
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 8,
   parameter int unsigned COUNT_W         = 8,
   parameter int unsigned STUCK_CYCLES    = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               loop_raw,
   input  logic               count_clr,
   vehicle_detector_if.master ctrl,
   output logic [COUNT_W-1:0] car_count,
   output logic               stuck
);

   det_state_t state, state_n;
   logic       pending, pending_n;
   logic       loop_db;
   logic       arrival;
   logic       force_idle;
   logic       green;

   assign green = is_green(ctrl.side_light);

   loop_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_loop_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .loop_raw(loop_raw),
      .loop_db (loop_db),
      .arrival (arrival)
   );

`ifdef STUCK_DETECT_EN
   localparam int unsigned OCC_W = $clog2(STUCK_CYCLES + 1);
   localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(STUCK_CYCLES);

   logic [OCC_W-1:0] occ_cnt;
   logic             stuck_hit;

   // Counter parks at the limit, so stuck_hit stays true for as long as the loop stays occupied.
   assign stuck_hit  = loop_db && (occ_cnt == OCC_LIMIT);
   assign force_idle = stuck_hit | stuck;

   // Measure continuous occupancy and flag a loop that never clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_cnt <= '0;
         stuck   <= 1'b0;
      end else begin
         if (!loop_db)
            occ_cnt <= '0;
         else if (!stuck_hit)
            occ_cnt <= occ_cnt + OCC_W'(1);
         stuck <= stuck_hit;
      end
   end
`else
   assign stuck      = 1'b0;
   assign force_idle = 1'b0;
`endif

   // Saturating arrival count; a clear in the same cycle as an arrival leaves 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         car_count <= '0;
      end else if (count_clr) begin
         car_count <= arrival ? COUNT_W'(1) : '0;
      end else if (arrival && (car_count != '1)) begin
         car_count <= car_count + COUNT_W'(1);
      end
   end

   // Next-state and pending logic for the request FSM.
   always_comb begin
      state_n   = state;
      pending_n = pending;
      case (state)
         IDLE: begin
            if (arrival)
               state_n = WAIT_SERVE;
         end
         WAIT_SERVE: begin
            if (green)
               state_n = SERVING;
         end
         SERVING: begin
            if (!green) begin
               state_n   = (pending || loop_db) ? WAIT_SERVE : IDLE;
               pending_n = 1'b0;
            end else if (arrival) begin
               pending_n = 1'b1;
            end
         end
         default: begin
            state_n   = IDLE;
            pending_n = 1'b0;
         end
      endcase
      if (force_idle) begin
         state_n   = IDLE;
         pending_n = 1'b0;
      end
   end

   // State, pending flag and the registered sensor decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pending     <= 1'b0;
         ctrl.sensor <= 1'b0;
      end else begin
         state       <= state_n;
         pending     <= pending_n;
         ctrl.sensor <= (state_n == WAIT_SERVE);
      end
   end

endmodule

// File: tb/tb_vehicle_detector.sv
// Self-checking bench for vehicle_detector. Randomized loop pulses are checked
// against a pulse-level model: a pulse is a vehicle iff it lasts >= DEBOUNCE_CYCLES.
module tb_vehicle_detector;
   import traffic_pkg::*;

   localparam int unsigned D  = 8;
   localparam int unsigned CW = 8;
   localparam int unsigned SC = 50;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          loop_raw;
   logic          count_clr;
   logic [CW-1:0] car_count;
   logic          stuck;

   int n_checks = 0;
   int n_fail   = 0;

   vehicle_detector_if bus ();

   vehicle_detector #(
      .DEBOUNCE_CYCLES(D),
      .COUNT_W        (CW),
      .STUCK_CYCLES   (SC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .loop_raw (loop_raw),
      .count_clr(count_clr),
      .ctrl     (bus),
      .car_count(car_count),
      .stuck    (stuck)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      loop_raw       = 1'b0;
      count_clr      = 1'b0;
      bus.side_light = RED;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (bus.sensor !== 1'b0) begin n_fail++; $display("FAIL reset_sensor: got %b expected 0", bus.sensor); end
      n_checks++;
      if (car_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", car_count); end
      n_checks++;
      if (stuck !== 1'b0) begin n_fail++; $display("FAIL reset_stuck: got %b expected 0", stuck); end
   endtask

   task automatic test_latency();
      do_reset();
      loop_raw = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         tick(1);
         if (e == 10) begin
            n_checks++;
            if (bus.sensor !== 1'b0) begin n_fail++; $display("FAIL latency_early: edge %0d got %b expected 0", e, bus.sensor); end
            n_checks++;
            if (car_count !== 8'd0) begin n_fail++; $display("FAIL latency_count_early: got %0d expected 0", car_count); end
         end
         if (e == 11) begin
            n_checks++;
            if (bus.sensor !== 1'b1) begin n_fail++; $display("FAIL latency_rise: edge %0d got %b expected 1", e, bus.sensor); end
            n_checks++;
            if (car_count !== 8'd1) begin n_fail++; $display("FAIL latency_count: got %0d expected 1", car_count); end
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      loop_raw = 1'b1;
      tick(5);
      loop_raw = 1'b0;
      tick(30);
      n_checks++;
      if (bus.sensor !== 1'b0) begin n_fail++; $display("FAIL glitch_sensor: got %b expected 0", bus.sensor); end
      n_checks++;
      if (car_count !== 8'd0) begin n_fail++; $display("FAIL glitch_count: got %0d expected 0", car_count); end
   endtask

   task automatic test_serve();
      do_reset();
      loop_raw = 1'b1;
      tick(11);
      n_checks++;
      if (bus.sensor !== 1'b1) begin n_fail++; $display("FAIL serve_request: got %b expected 1", bus.sensor); end
      bus.side_light = GREEN;
      tick(1);
      n_checks++;
      if (bus.sensor !== 1'b0) begin n_fail++; $display("FAIL serve_ack: got %b expected 0", bus.sensor); end
      loop_raw = 1'b0;
      tick(D + 4);
      bus.side_light = RED;
      tick(1);
      n_checks++;
      if (bus.sensor !== 1'b0) begin n_fail++; $display("FAIL serve_exit: got %b expected 0", bus.sensor); end
      tick(3);
      n_checks++;
      if (bus.sensor !== 1'b0) begin n_fail++; $display("FAIL serve_idle: got %b expected 0", bus.sensor); end
   endtask

   task automatic test_pending();
      do_reset();
      loop_raw = 1'b1;
      tick(11);
      bus.side_light = GREEN;
      tick(1);
      loop_raw = 1'b0;
      tick(D + 4);
      loop_raw = 1'b1;
      tick(D + 3);
      loop_raw = 1'b0;
      tick(D + 4);
      n_checks++;
      if (bus.sensor !== 1'b0) begin n_fail++; $display("FAIL pending_hold: got %b expected 0", bus.sensor); end
      bus.side_light = YELLOW;
      tick(1);
      n_checks++;
      if (bus.sensor !== 1'b1) begin n_fail++; $display("FAIL pending_rerequest: got %b expected 1", bus.sensor); end
      n_checks++;
      if (car_count !== 8'd2) begin n_fail++; $display("FAIL pending_count: got %0d expected 2", car_count); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 260; i++) begin
         loop_raw = 1'b1;
         tick(D + 2);
         loop_raw = 1'b0;
         tick(D + 4);
      end
      n_checks++;
      if (car_count !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d expected 255", car_count); end
      loop_raw = 1'b1;
      tick(D + 2);
      count_clr = 1'b1;
      tick(1);
      count_clr = 1'b0;
      n_checks++;
      if (car_count !== 8'd1) begin n_fail++; $display("FAIL clr_with_arrival: got %0d expected 1", car_count); end
      loop_raw = 1'b0;
      tick(D + 4);
      count_clr = 1'b1;
      tick(1);
      count_clr = 1'b0;
      n_checks++;
      if (car_count !== 8'd0) begin n_fail++; $display("FAIL clr_plain: got %0d expected 0", car_count); end
   endtask

   task automatic test_random();
      int unsigned len, gap;
      int unsigned exp_count;
      do_reset();
      exp_count = 0;
      repeat (25) begin
         len = $urandom_range(2 * D, 1);
         gap = $urandom_range(D + 10, D + 2);
         loop_raw = 1'b1;
         tick(int'(len));
         loop_raw = 1'b0;
         tick(int'(gap));
         if (len >= D && exp_count < 255) exp_count++;
         n_checks++;
         if (car_count !== CW'(exp_count)) begin
            n_fail++;
            $display("FAIL rand_count: len %0d got %0d expected %0d", len, car_count, exp_count);
         end
         n_checks++;
         if (bus.sensor !== (exp_count > 0)) begin
            n_fail++;
            $display("FAIL rand_sensor: got %b expected %b", bus.sensor, (exp_count > 0));
         end
         n_checks++;
         if (stuck !== 1'b0) begin n_fail++; $display("FAIL rand_stuck: got %b expected 0", stuck); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      loop_raw = 1'b1;
      tick(12);
      n_checks++;
      if (bus.sensor !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b expected 1", bus.sensor); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.sensor !== 1'b0) begin n_fail++; $display("FAIL mid_sensor: got %b expected 0", bus.sensor); end
      n_checks++;
      if (car_count !== 8'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", car_count); end
      n_checks++;
      if (stuck !== 1'b0) begin n_fail++; $display("FAIL mid_stuck: got %b expected 0", stuck); end
      tick(1);
      rst_n = 1'b1;
      tick(10);
      n_checks++;
      if (bus.sensor !== 1'b0) begin n_fail++; $display("FAIL redetect_early: got %b expected 0", bus.sensor); end
      tick(1);
      n_checks++;
      if (bus.sensor !== 1'b1) begin n_fail++; $display("FAIL redetect_rise: got %b expected 1", bus.sensor); end
      n_checks++;
      if (car_count !== 8'd1) begin n_fail++; $display("FAIL redetect_count: got %0d expected 1", car_count); end
   endtask

`ifdef STUCK_DETECT_EN
   task automatic test_stuck();
      do_reset();
      loop_raw = 1'b1;
      tick(11);
      tick(49);
      n_checks++;
      if (stuck !== 1'b0) begin n_fail++; $display("FAIL stuck_early: got %b expected 0", stuck); end
      n_checks++;
      if (bus.sensor !== 1'b1) begin n_fail++; $display("FAIL stuck_early_sensor: got %b expected 1", bus.sensor); end
      tick(1);
      n_checks++;
      if (stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_set: got %b expected 1", stuck); end
      n_checks++;
      if (bus.sensor !== 1'b0) begin n_fail++; $display("FAIL stuck_sensor: got %b expected 0", bus.sensor); end
      tick(20);
      n_checks++;
      if (stuck !== 1'b1 || bus.sensor !== 1'b0) begin
         n_fail++;
         $display("FAIL stuck_hold: got stuck %b sensor %b expected 1 0", stuck, bus.sensor);
      end
      loop_raw = 1'b0;
      tick(D + 2);
      n_checks++;
      if (stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_release_early: got %b expected 1", stuck); end
      tick(1);
      n_checks++;
      if (stuck !== 1'b0) begin n_fail++; $display("FAIL stuck_release: got %b expected 0", stuck); end
      n_checks++;
      if (bus.sensor !== 1'b0 || car_count !== 8'd1) begin
         n_fail++;
         $display("FAIL stuck_after: got sensor %b count %0d expected 0 1", bus.sensor, car_count);
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_serve();
      test_pending();
      test_saturation();
      test_random();
      test_reset_mid();
`ifdef STUCK_DETECT_EN
      test_stuck();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
